// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns engine: input transaction,
// output result, status and abort.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic         flush;

    modport master (
        output in_valid, in_inv, in_state, out_ready, flush,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_inv, in_state, out_ready, flush,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns
// per clock, with valid/ready handshakes on both sides and a synchronous flush.
module mix_col_lane (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // index 0 is row 0 (the MSB byte of the column)
    logic [0:3][7:0] a, x2, x4, x8, fwd, bwd;
    assign a = col;

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;
        assign x2[r] = xt(a[r]);
        assign x4[r] = xt(x2[r]);
        assign x8[r] = xt(x4[r]);
        // rows of [02 03 01 01] and [0E 0B 0D 09], rotated by r
        assign fwd[r] = x2[r] ^ (x2[R1] ^ a[R1]) ^ a[R2] ^ a[R3];
        assign bwd[r] = (x8[r] ^ x4[r] ^ x2[r]) ^ (x8[R1] ^ x2[R1] ^ a[R1])
                      ^ (x8[R2] ^ x4[R2] ^ a[R2]) ^ (x8[R3] ^ a[R3]);
    end

    assign res = inv ? bwd : fwd;
endmodule

module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus
);
    localparam int NCYC = 4 / COLS_PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]          cnt;
    logic                   inv_q;
    logic [0:3][31:0]       st, st_nx;   // index c is column c
    logic [127:0]           out_q;
    logic [COLS_PER_CYCLE-1:0][1:0]  idx;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_res;

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign idx[l]     = 2'(int'(cnt) * COLS_PER_CYCLE + l);
        assign lane_in[l] = st[idx[l]];
        mix_col_lane u_lane (.col(lane_in[l]), .inv(inv_q), .res(lane_res[l]));
    end

    always_comb begin
        st_nx = st;
        for (int l = 0; l < COLS_PER_CYCLE; l++) st_nx[idx[l]] = lane_res[l];
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = BUSY;
            BUSY:    if (cnt == LAST)   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
        if (bus.flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            inv_q <= 1'b0;
            st    <= '0;
            out_q <= '0;
        end else begin
            state <= state_nx;
            if (bus.flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (bus.in_valid) begin
                        st    <= bus.in_state;
                        inv_q <= bus.in_inv;
                        cnt   <= '0;
                    end
                    BUSY: begin
                        st <= st_nx;
                        // result register only moves when a new result completes
                        if (cnt == LAST) out_q <= st_nx;
                        else             cnt   <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_state = out_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and randomised checks of mix_columns_seq for C=1, 2 and 4 driven
// in lockstep from one shared stimulus.
module tb_mix_columns_seq;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 0, in_inv = 0, out_ready = 0, flush = 0;
    logic [127:0] in_state = '0;
    always #5 clk = ~clk;

    mix_columns_seq_if if1 (), if2 (), if4 ();
    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    assign if1.in_valid = in_valid; assign if2.in_valid = in_valid; assign if4.in_valid = in_valid;
    assign if1.in_inv = in_inv;     assign if2.in_inv = in_inv;     assign if4.in_inv = in_inv;
    assign if1.in_state = in_state; assign if2.in_state = in_state; assign if4.in_state = in_state;
    assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;
    assign if1.flush = flush;       assign if2.flush = flush;       assign if4.flush = flush;

    logic [2:0] ov, ir, bz;
    logic [2:0][127:0] os;
    assign ov = {if4.out_valid, if2.out_valid, if1.out_valid};
    assign ir = {if4.in_ready, if2.in_ready, if1.in_ready};
    assign bz = {if4.busy, if2.busy, if1.busy};
    assign os = {if4.out_state, if2.out_state, if1.out_state};

    int nerr = 0, nchk = 0;
    int ncyc [3] = '{4, 2, 1};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] base [4];
        logic [127:0] o = '0;
        logic [7:0] acc;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc ^= gm(base[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        return o;
    endfunction

    // One transaction on all three engines; checks latency and result per engine.
    task automatic run_txn(input string name, input logic inv, input logic [127:0] din,
                           input logic [127:0] exp);
        int lat [3];
        logic [127:0] res [3];
        lat = '{0, 0, 0};
        res = '{default: '0};
        @(negedge clk); in_inv = inv; in_state = din; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_state = ~din; in_inv = ~inv;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                if (ov[d] && lat[d] == 0) begin lat[d] = n; res[d] = os[d]; end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_lat_d%0d", name, d), 128'(lat[d]), 128'(ncyc[d]));
            chk($sformatf("%s_data_d%0d", name, d), res[d], exp);
        end
    endtask

    typedef struct { string name; logic inv; logic [127:0] din; logic [127:0] exp; } vec_t;
    vec_t tbl [6];

    localparam logic [127:0] PA = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] PB = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] PC = 128'hd4d4d4d52d26314c0000000000000000;
    localparam logic [127:0] PD = 128'hd5d5d7d64d7ebdf80000000000000000;

    initial begin
        int found, seen;
        logic [127:0] din, res;
        logic inv;
        tbl[0] = '{"fwd_fips",  1'b0, PA, PB};
        tbl[1] = '{"inv_fips",  1'b1, PB, PA};
        tbl[2] = '{"fwd_rt",    1'b0, PC, PD};
        tbl[3] = '{"inv_rt",    1'b1, PD, PC};
        tbl[4] = '{"fwd_zero",  1'b0, '0, '0};
        tbl[5] = '{"inv_zero",  1'b1, '0, '0};

        repeat (2) @(posedge clk);
        #1; chk("rst_ovalid", 128'(ov), 0); chk("rst_busy", 128'(bz), 0);
        chk("rst_ostate", os, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_iready", 128'(ir), 128'(3'b111));

        for (int i = 0; i < 6; i++) run_txn(tbl[i].name, tbl[i].inv, tbl[i].din, tbl[i].exp);

        // backpressure: result held, second transaction waits for the handshake
        @(negedge clk); in_state = PA; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; in_state = PB; in_inv = 1'b1;
        found = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ov[0]) begin found = n; break; end
        end
        chk("bp_lat", 128'(found), 128'd4);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk("bp_hold_data", os[0], PB);
            chk("bp_hold_iready", 128'(ir), 0);
            chk("bp_hold_ovalid", 128'(ov[0]), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_iready", 128'(ir[0]), 1); chk("bp_hs_ovalid", 128'(ov[0]), 0);
        chk("bp_hs_keep", os[0], PB);
        @(posedge clk); #1;
        chk("bp_acc2_busy", 128'(bz[0]), 1);
        in_valid = 1'b0;
        found = 0; res = '0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ov[0] && found == 0) begin found = n; res = os[0]; end
        end
        chk("bp_t2_lat", 128'(found), 128'd4); chk("bp_t2_data", res, PA);

        // flush in the second BUSY cycle of a C=1 transaction
        @(negedge clk); in_state = PC; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", 128'(bz[0]), 0); chk("flush_iready", 128'(ir[0]), 1);
        seen = 0;
        for (int n = 0; n < 6; n++) begin @(posedge clk); #1; if (ov[0]) seen = 1; end
        chk("flush_no_ovalid", 128'(seen), 0);
        chk("flush_keep_out", os[0], PA);
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; in_state = PB;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_noacc", 128'(bz), 0);
        run_txn("after_flush", 1'b0, PC, PD);

        // asynchronous reset while C=1 is busy and C=4 already presents a result
        @(negedge clk); in_state = PA; in_inv = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_ovalid4", 128'(ov[2]), 1);
        #2 rst_n = 1'b0;
        #1; chk("arst_ovalid", 128'(ov), 0); chk("arst_busy", 128'(bz), 0);
        chk("arst_ostate", os, '0);
        @(negedge clk); rst_n = 1'b1;
        #1; chk("arst_iready", 128'(ir), 128'(3'b111));

        for (int i = 0; i < 1000; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            run_txn("rand", inv, din, model(din, inv));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Sequential, handshaked AES MixColumns / InvMixColumns engine; the parametrised successor to the combinational mix_columns.
- Processes COLS_PER_CYCLE columns of the 128-bit state per clock.
- Selects forward or inverse transform per transaction.
- Sits between the ShiftRows stage and AddRoundKey in the iterative round datapath of the AES core.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle. Legal values 1, 2, 4; any other value is an elaboration error ($error).
- NCYC, 4/COLS_PER_CYCLE, derived localparam (not overridable): number of compute cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept a transaction.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_state.
- in_state  in  128  input state.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_state  out  128  transformed state.
- busy  out  1  high in BUSY or DONE.
- flush  in  1  synchronous abort.

Behaviour:
- Byte order:
  - Column c occupies in_state[127-32c -: 32], c = 0..3.
  - Within a column, the MSB byte is row 0.
  - This is the FIPS-197 s(r,c) mapping, identical to mix_columns.
- Arithmetic (all GF(2^8), polynomial 0x11B):
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - Forward matrix rows: [02 03 01 01] rotated.
  - Inverse matrix rows: [0E 0B 0D 09] rotated.
  - Products are built only from xtime chains and XOR; no multipliers, no LUT ROM.
- FSM states: IDLE, BUSY, DONE.
- Reset (rst_n low, async):
  - State goes to IDLE; column counter = 0.
  - Internal state register = 0; out_state = 0.
  - out_valid = 0, busy = 0, in_ready = 1 from reset release.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_state and in_inv, counter = 0, go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, columns counter*C .. counter*C+C-1 are replaced in the state register with their transform, using the latched mode.
  - When counter reaches NCYC-1, go to DONE; otherwise counter increments.
- DONE:
  - out_valid = 1; out_state = the state register.
  - out_state is stable while out_valid is high and out_ready is low (backpressure may last indefinitely).
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - in_ready = 0 throughout DONE, so there is no same-cycle accept on output handshake.
- Latency: input accepted at edge k → out_valid high after edge k+NCYC (C=4: 1 cycle; C=2: 2; C=1: 4).
- Throughput: one transaction per NCYC+2 cycles, given immediate out_ready and back-to-back in_valid.
- in_inv and in_state changes after acceptance have no effect on the in-flight transaction.
- flush (synchronous, highest priority after reset):
  - Forces IDLE, counter = 0, out_valid = 0 next cycle.
  - Data register is not cleared.
  - flush in IDLE together with in_valid: the input is not accepted.
- out_state:
  - Holds the last result after the handshake until the next result.
  - Reads 0 only after reset.
- No combinational path from in_valid or out_ready to any output; all outputs are registered or decoded from FSM state.

Test Plan:
1. Forward transform, C=1, in_inv=0, in_state=db135345f20a225c01010101c6c6c6c6
   - out_state = 8e4da1bc9fdc589d01010101c6c6c6c6.
   - out_valid rises exactly 4 cycles after accept.
2. Inverse transform, in_inv=1, in_state=8e4da1bc9fdc589d01010101c6c6c6c6
   - out_state = db135345f20a225c01010101c6c6c6c6.
   - Repeat for C=2 (latency 2) and C=4 (latency 1).
3. Round trip and column independence:
   - d4d4d4d52d26314c0000000000000000 forward → d5d5d7d64d7ebdf80000000000000000.
   - Feeding that result back inverse returns the original.
   - 128'h0 → 128'h0.
4. Backpressure:
   - Hold out_ready=0 for 10 cycles while driving in_valid with new data.
   - out_state stays constant, in_ready stays 0, and the second transaction is accepted only after the handshake.
5. flush:
   - flush in cycle 2 of a C=1 transaction → IDLE next cycle, out_valid never rises.
   - The next transaction produces the correct result.
6. Reset mid-BUSY:
   - Asserting rst_n=0 asynchronously clears out_valid/busy immediately, with out_state = 0.
   - in_ready = 1 after release.
   - Randomised comparison against a reference-model sweep: 1000 vectors per C, both modes.
